// File: rtl/run_seq_pkg.sv
// Shared encodings for the run sequencer: FSM state values and phase indices.
package run_seq_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StHold = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } run_state_e;

  localparam logic [1:0] PhImem = 2'd0;
  localparam logic [1:0] PhProc = 2'd1;
  localparam logic [1:0] PhDmem = 2'd2;
  localparam logic [1:0] PhReg  = 2'd3;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable, synchronous clear and terminal-count flag.
module mod_counter #(
  parameter int unsigned Width   = 2,
  parameter int unsigned Modulus = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] count,
  output logic             tc
);

  localparam logic [Width-1:0] MaxCount = Width'(Modulus - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == MaxCount) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == MaxCount);

endmodule

// File: rtl/run_sequencer.sv
// Run controller: holds the core in reset, then sequences one-hot phase enables
// for a bounded number of processor cycles (or until halt) and parks in DONE.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned RUN_CYCLES   = 150,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pause,
  input  logic             halt_in,
  output logic             proc_reset,
  output logic             imem_en,
  output logic             proc_en,
  output logic             dmem_en,
  output logic             regfile_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic [1:0]       state
);

  localparam int unsigned      HoldW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RunLimit = CNT_W'(RUN_CYCLES);
  localparam bit               NoRun    = (RUN_CYCLES == 0);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, cycle_inc;
  logic             halt_q, halt_d;

  logic             hold_tc;
  logic [HoldW-1:0] unused_hold_cnt;
  logic [1:0]       phase;
  logic             phase_tc;
  logic             run_active;
  logic             cycle_end;

  assign run_active = (state_q == StRun) && !pause;
  // A processor cycle completes on the edge that leaves phase 3.
  assign cycle_end  = run_active && phase_tc;
  assign cycle_inc  = cycle_q + 1'b1;

  mod_counter #(
    .Width   (HoldW),
    .Modulus (RESET_CYCLES)
  ) u_hold_cnt (
    .clock (clock),
    .reset (reset),
    .en    (state_q == StHold),
    .clr   (state_q != StHold),
    .count (unused_hold_cnt),
    .tc    (hold_tc)
  );

  mod_counter #(
    .Width   (2),
    .Modulus (4)
  ) u_phase_cnt (
    .clock (clock),
    .reset (reset),
    .en    (run_active),
    .clr   (state_q == StHold),
    .count (phase),
    .tc    (phase_tc)
  );

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    halt_d  = halt_q;
    case (state_q)
      StHold: begin
        if (hold_tc) begin
          state_d = NoRun ? StDone : StRun;
        end
      end
      StRun: begin
        halt_d = halt_q | halt_in;
        if (cycle_end) begin
          cycle_d = cycle_inc;
          if (halt_q || halt_in || (cycle_inc == RunLimit)) begin
            state_d = StDone;
          end
        end
      end
      StDone: ;
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StHold;
      cycle_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      halt_q  <= halt_d;
    end
  end

  assign proc_reset  = (state_q == StHold);
  assign imem_en     = run_active && (phase == PhImem);
  assign proc_en     = run_active && (phase == PhProc);
  assign dmem_en     = run_active && (phase == PhDmem);
  assign regfile_en  = run_active && (phase == PhReg);
  assign done        = (state_q == StDone);
  assign state       = state_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench: directed stimulus pushes per-clock expected outputs, a
// negedge monitor pops and compares against the sampled DUT outputs.
module tb_run_sequencer;

  logic        clock;
  logic        reset, pause, halt_in;
  logic        proc_reset, imem_en, proc_en, dmem_en, regfile_en, done;
  logic [15:0] cycle_count;
  logic [1:0]  state;

  logic        reset_b, pause_b, halt_b;
  logic        proc_reset_b, imem_b, proc_b, dmem_b, reg_b, done_b;
  logic [15:0] cycle_count_b;
  logic [1:0]  state_b;

  run_sequencer #(
    .RESET_CYCLES (2),
    .RUN_CYCLES   (150),
    .CNT_W        (16)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .pause       (pause),
    .halt_in     (halt_in),
    .proc_reset  (proc_reset),
    .imem_en     (imem_en),
    .proc_en     (proc_en),
    .dmem_en     (dmem_en),
    .regfile_en  (regfile_en),
    .cycle_count (cycle_count),
    .done        (done),
    .state       (state)
  );

  run_sequencer #(
    .RESET_CYCLES (1),
    .RUN_CYCLES   (0),
    .CNT_W        (16)
  ) u_dut_b (
    .clock       (clock),
    .reset       (reset_b),
    .pause       (pause_b),
    .halt_in     (halt_b),
    .proc_reset  (proc_reset_b),
    .imem_en     (imem_b),
    .proc_en     (proc_b),
    .dmem_en     (dmem_b),
    .regfile_en  (reg_b),
    .cycle_count (cycle_count_b),
    .done        (done_b),
    .state       (state_b)
  );

  typedef struct {
    bit          sel;
    logic [23:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [23:0] mon_got;
  int          checks;
  int          failures;
  int          rf_pulses;
  bit          b_en_seen;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Vector layout: {proc_reset, imem, proc, dmem, regfile, done, state, cycle_count}
  function automatic logic [23:0] hold_e();
    return {1'b1, 4'b0000, 1'b0, 2'd0, 16'd0};
  endfunction

  function automatic logic [23:0] run_e(input int ph, input int cnt, input bit paused);
    logic [3:0] en;
    logic [3:0] onehot;
    onehot = 4'b1000;
    en = paused ? 4'b0000 : (onehot >> ph);
    return {1'b0, en, 1'b0, 2'd1, cnt[15:0]};
  endfunction

  function automatic logic [23:0] done_e(input int cnt);
    return {1'b0, 4'b0000, 1'b1, 2'd2, cnt[15:0]};
  endfunction

  always @(negedge clock) begin
    if (regfile_en === 1'b1) rf_pulses++;
    if ((imem_b | proc_b | dmem_b | reg_b) === 1'b1) b_en_seen = 1'b1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_got = mon_e.sel
          ? {proc_reset_b, imem_b, proc_b, dmem_b, reg_b, done_b, state_b, cycle_count_b}
          : {proc_reset, imem_en, proc_en, dmem_en, regfile_en, done, state, cycle_count};
      checks++;
      if (mon_got !== mon_e.exp) begin
        failures++;
        $display("FAIL %s: got %h required %h", mon_e.tag, mon_got, mon_e.exp);
      end
    end
  end

  task automatic cyc(input bit sel, input bit chk, input logic r, input logic p, input logic h,
                     input logic [23:0] e, input string tag);
    exp_t it;
    @(posedge clock);
    #1;
    if (sel) begin
      reset_b = r; pause_b = p; halt_b = h;
    end else begin
      reset = r; pause = p; halt_in = h;
    end
    if (chk) begin
      it.sel = sel; it.exp = e; it.tag = tag;
      sb_q.push_back(it);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Starts in HOLD with hold count 0 and releases reset.
  task automatic release_a(input logic p_hold);
    cyc(1'b0, 1'b1, 1'b0, p_hold, 1'b0, hold_e(), "hold0");
    cyc(1'b0, 1'b1, 1'b0, p_hold, 1'b0, hold_e(), "hold1");
  endtask

  task automatic run_cycles(input int first, input int last);
    for (int c = first; c < last; c++)
      for (int ph = 0; ph < 4; ph++)
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, run_e(ph, c, 1'b0), $sformatf("run c%0d p%0d", c, ph));
  endtask

  task automatic done_cycles(input int n, input int cnt);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, 1'b0, i[0], i[1], done_e(cnt), $sformatf("done %0d", i));
  endtask

  task automatic phase_at(input int c, input int ph, input logic p, input logic h);
    cyc(1'b0, 1'b1, 1'b0, p, h, run_e(ph, c, p), $sformatf("c%0d p%0d pause%0b", c, ph, p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; rf_pulses = 0; b_en_seen = 1'b0;
    reset = 1'b1; pause = 1'b0; halt_in = 1'b0;
    reset_b = 1'b1; pause_b = 1'b0; halt_b = 1'b0;

    // Default run: two reset clocks, then 602 clocks to DONE.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, hold_e(), "rst0");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, hold_e(), "rst1");
    rf_pulses = 0;
    release_a(1'b0);
    run_cycles(0, 150);
    done_cycles(4, 150);
    check_int("rf_pulses_full", rf_pulses, 150);

    // Halt pulse at phase 1 of processor cycle 10.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, done_e(150), "rst_from_done");
    rf_pulses = 0;
    release_a(1'b0);
    run_cycles(0, 10);
    phase_at(10, 0, 1'b0, 1'b0);
    phase_at(10, 1, 1'b0, 1'b1);
    phase_at(10, 2, 1'b0, 1'b0);
    phase_at(10, 3, 1'b0, 1'b0);
    done_cycles(6, 11);
    check_int("rf_pulses_halt", rf_pulses, 11);

    // Pause ignored in HOLD; 5-clock pause at phase 2 of cycle 20.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, done_e(11), "rst_from_halt");
    release_a(1'b1);
    run_cycles(0, 20);
    phase_at(20, 0, 1'b0, 1'b0);
    phase_at(20, 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) phase_at(20, 2, 1'b1, 1'b0);
    phase_at(20, 2, 1'b0, 1'b0);
    phase_at(20, 3, 1'b0, 1'b0);
    run_cycles(21, 150);
    done_cycles(2, 150);

    // Reset asserted for one clock at cycle_count=40, then a full run.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, done_e(150), "rst_from_pause");
    release_a(1'b0);
    run_cycles(0, 40);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, run_e(0, 40, 1'b0), "mid_run_reset");
    release_a(1'b0);
    run_cycles(0, 150);
    done_cycles(2, 150);

    // Halt raised while paused is still latched.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, done_e(150), "rst_before_paused_halt");
    release_a(1'b0);
    run_cycles(0, 3);
    phase_at(3, 0, 1'b0, 1'b0);
    phase_at(3, 1, 1'b0, 1'b0);
    phase_at(3, 2, 1'b1, 1'b1);
    phase_at(3, 2, 1'b1, 1'b0);
    phase_at(3, 2, 1'b0, 1'b0);
    phase_at(3, 3, 1'b0, 1'b0);
    done_cycles(2, 4);

    // Halt held high from RUN entry: one processor cycle, then DONE.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, done_e(4), "rst_before_cont_halt");
    release_a(1'b0);
    for (int ph = 0; ph < 4; ph++) phase_at(0, ph, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 1'b0, i[0], 1'b1, done_e(1), $sformatf("cont_halt_done %0d", i));
    pause = 1'b0; halt_in = 1'b0;

    // RUN_CYCLES=0, RESET_CYCLES=1: DONE one clock after release.
    b_en_seen = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, hold_e(), "b_rst");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, hold_e(), "b_hold0");
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 1'b0, i[0], i[1], done_e(0), $sformatf("b_done %0d", i));
    @(negedge clock);
    @(negedge clock);
    check_int("b_enable_seen", int'(b_en_seen), 0);
    check_int("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
